// File: rtl/adder_result_checker.sv
// adder_result_checker: recomputes the golden adder result for every issued operation and
// compares it against the DUT output LATENCY cycles later, keeping counts and the first error.
`default_nettype none
`timescale 1ns/1ps

module adder_result_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             issue_valid,
  input  logic [WIDTH-1:0] issue_a,
  input  logic [WIDTH-1:0] issue_b,
  input  logic             issue_op,
  input  logic [WIDTH:0]   dut_c,
  input  logic             end_of_test,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             mismatch,
  output logic             first_err_valid,
  output logic [WIDTH:0]   first_err_exp,
  output logic [WIDTH:0]   first_err_got,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [LATENCY-1:0]   vld_q;
  logic [WIDTH:0]       exp_q [LATENCY];
  logic [CNT_W-1:0]     pass_q, pass_d, fail_q, fail_d;
  logic                 mis_q, mis_d, fev_q, fev_d;
  logic [WIDTH:0]       fee_q, fee_d, feg_q, feg_d;
  logic [WIDTH:0]       golden;
  logic                 accept, retire, hit;

  always_comb begin
    if (issue_op) golden = {1'b0, issue_a} - {1'b0, issue_b};
    else          golden = {1'b0, issue_a} + {1'b0, issue_b};
  end

  // Operations arriving after end_of_test are never entered into the pipeline.
  assign accept = issue_valid && (state_q == S_IDLE || state_q == S_RUN);
  assign retire = vld_q[LATENCY-1];
  assign hit    = (exp_q[LATENCY-1] == dut_c);

  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    mis_d  = 1'b0;
    fev_d  = fev_q;
    fee_d  = fee_q;
    feg_d  = feg_q;
    if (retire) begin
      if (hit) begin
        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
      end else begin
        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
        mis_d = 1'b1;
        if (!fev_q) begin
          fev_d = 1'b1;
          fee_d = exp_q[LATENCY-1];
          feg_d = dut_c;
        end
      end
    end
    if (clear) begin
      pass_d = '0;
      fail_d = '0;
      mis_d  = 1'b0;
      fev_d  = 1'b0;
      fee_d  = '0;
      feg_d  = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (end_of_test) state_d = S_DRAIN;
               else if (issue_valid) state_d = S_RUN;
      S_RUN:   if (end_of_test) state_d = S_DRAIN;
      S_DRAIN: if (!busy) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      vld_q   <= '0;
      for (int i = 0; i < LATENCY; i++) exp_q[i] <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      mis_q   <= 1'b0;
      fev_q   <= 1'b0;
      fee_q   <= '0;
      feg_q   <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      mis_q   <= mis_d;
      fev_q   <= fev_d;
      fee_q   <= fee_d;
      feg_q   <= feg_d;
      for (int i = LATENCY - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
      vld_q[0] <= accept;
      exp_q[0] <= golden;
      if (clear) vld_q <= '0;
    end
  end

  assign pass_cnt        = pass_q;
  assign fail_cnt        = fail_q;
  assign mismatch        = mis_q;
  assign first_err_valid = fev_q;
  assign first_err_exp   = fee_q;
  assign first_err_got   = feg_q;
  assign busy            = |vld_q;
  assign done            = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: two instances (LATENCY 1 / CNT_W 16 and LATENCY 3 / CNT_W 2)
// driven by one stimulus stream and compared every cycle against a queue-based model.
`default_nettype none
`timescale 1ns/1ps

module tb_adder_result_checker;
  localparam int W   = 4;
  localparam int LAT0 = 1, LAT1 = 3;
  localparam int CW0  = 16, CW1 = 2;
  localparam int IDLE = 0, RUN = 1, DRAIN = 2, DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, clear, issue_valid, issue_op, end_of_test;
  logic [W-1:0] issue_a, issue_b;
  logic [W:0]   dut_c0, dut_c1;

  logic [CW0-1:0] pass0, fail0;
  logic [CW1-1:0] pass1, fail1;
  logic           mis0, mis1, fev0, fev1, busy0, busy1, done0, done1;
  logic [W:0]     fee0, feg0, fee1, feg1;

  adder_result_checker #(.WIDTH(W), .LATENCY(LAT0), .CNT_W(CW0)) u_dut0 (
    .clk(clk), .reset(reset), .clear(clear), .issue_valid(issue_valid),
    .issue_a(issue_a), .issue_b(issue_b), .issue_op(issue_op), .dut_c(dut_c0),
    .end_of_test(end_of_test), .pass_cnt(pass0), .fail_cnt(fail0), .mismatch(mis0),
    .first_err_valid(fev0), .first_err_exp(fee0), .first_err_got(feg0),
    .busy(busy0), .done(done0));

  adder_result_checker #(.WIDTH(W), .LATENCY(LAT1), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .reset(reset), .clear(clear), .issue_valid(issue_valid),
    .issue_a(issue_a), .issue_b(issue_b), .issue_op(issue_op), .dut_c(dut_c1),
    .end_of_test(end_of_test), .pass_cnt(pass1), .fail_cnt(fail1), .mismatch(mis1),
    .first_err_valid(fev1), .first_err_exp(fee1), .first_err_got(feg1),
    .busy(busy1), .done(done1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         k;
    int         due;
    logic [W:0] exp;
  } item_t;

  item_t      q[$];
  int         lat_of[2] = '{LAT0, LAT1};
  int         cmax[2]   = '{(1 << CW0) - 1, (1 << CW1) - 1};
  int         m_pass[2], m_fail[2], m_state[2];
  bit         m_mis[2], m_fev[2];
  logic [W:0] m_fee[2], m_feg[2];
  int         edge_no = 0;
  logic [W:0] hist[int];

  function automatic logic [W:0] gold(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    r  = op ? (ia - ib + (1 << (W + 1))) % (1 << (W + 1)) : ia + ib;
    return r[W:0];
  endfunction

  function automatic int inflight(input int k);
    int n = 0;
    foreach (q[i]) if (q[i].k == k) n++;
    return n;
  endfunction

  task automatic model_flush(input int k);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].k == k) q.delete(i);
    m_pass[k] = 0; m_fail[k] = 0; m_mis[k] = 0; m_fev[k] = 0;
    m_fee[k] = '0; m_feg[k] = '0; m_state[k] = IDLE;
  endtask

  task automatic model_edge(input int k, input logic [W:0] c);
    bit         busy_pre, found;
    logic [W:0] e;
    item_t      it;
    if (clear) begin
      model_flush(k);
      return;
    end
    busy_pre = inflight(k) > 0;
    found    = 0;
    e        = '0;
    m_mis[k] = 0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].k == k && q[i].due == edge_no) begin
        e = q[i].exp;
        found = 1;
        q.delete(i);
      end
    if (found) begin
      if (e == c) begin
        if (m_pass[k] < cmax[k]) m_pass[k]++;
      end else begin
        if (m_fail[k] < cmax[k]) m_fail[k]++;
        m_mis[k] = 1;
        if (!m_fev[k]) begin
          m_fev[k] = 1; m_fee[k] = e; m_feg[k] = c;
        end
      end
    end
    if (issue_valid && (m_state[k] == IDLE || m_state[k] == RUN)) begin
      it.k = k; it.due = edge_no + lat_of[k]; it.exp = gold(issue_a, issue_b, issue_op);
      q.push_back(it);
    end
    case (m_state[k])
      IDLE:  if (end_of_test) m_state[k] = DRAIN; else if (issue_valid) m_state[k] = RUN;
      RUN:   if (end_of_test) m_state[k] = DRAIN;
      DRAIN: if (!busy_pre) m_state[k] = DONE;
      default: ;
    endcase
  endtask

  task automatic cmp(input int k, input int pc, input int fc, input int mi, input int fv,
                     input int fe, input int fg, input int bs, input int dn);
    check($sformatf("pass_cnt[%0d]", k), pc, m_pass[k]);
    check($sformatf("fail_cnt[%0d]", k), fc, m_fail[k]);
    check($sformatf("mismatch[%0d]", k), mi, int'(m_mis[k]));
    check($sformatf("first_err_valid[%0d]", k), fv, int'(m_fev[k]));
    check($sformatf("first_err_exp[%0d]", k), fe, int'(m_fee[k]));
    check($sformatf("first_err_got[%0d]", k), fg, int'(m_feg[k]));
    check($sformatf("busy[%0d]", k), bs, int'(inflight(k) > 0));
    check($sformatf("done[%0d]", k), dn, int'(m_state[k] == DONE));
  endtask

  // Compare process: advance the model for the rising edge just passed, then check both DUTs.
  initial begin
    for (int k = 0; k < 2; k++) model_flush(k);
    forever begin
      @(negedge clk);
      edge_no++;
      if (!reset) begin
        model_flush(0);
        model_flush(1);
      end else begin
        model_edge(0, dut_c0);
        model_edge(1, dut_c1);
      end
      cmp(0, int'(pass0), int'(fail0), int'(mis0), int'(fev0), int'(fee0), int'(feg0), int'(busy0), int'(done0));
      cmp(1, int'(pass1), int'(fail1), int'(mis1), int'(fev1), int'(fee1), int'(feg1), int'(busy1), int'(done1));
    end
  end

  // ---------------- stimulus ----------------
  // The emulated adder returns the golden value of the operation issued LATENCY edges earlier,
  // optionally with bit 0 flipped to provoke a mismatch.
  task automatic cycle(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b, input bit op,
                       input bit eot, input bit bad, input bit clr);
    int e;
    e = edge_no + 1;
    issue_valid = iv; issue_a = a; issue_b = b; issue_op = op;
    end_of_test = eot; clear = clr;
    if (iv) hist[e] = gold(a, b, op) ^ {{W{1'b0}}, bad};
    dut_c0 = hist.exists(e - LAT0) ? hist[e - LAT0] : (W + 1)'($urandom);
    dut_c1 = hist.exists(e - LAT1) ? hist[e - LAT1] : (W + 1)'($urandom);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 9) < 7, W'($urandom), W'($urandom), 1'($urandom),
            0, $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
  endtask

  initial begin
    int n;
    reset = 0; clear = 0; issue_valid = 0; issue_a = '0; issue_b = '0; issue_op = 0;
    end_of_test = 0; dut_c0 = '0; dut_c1 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset pass_cnt", int'(pass0), 0);
    check("reset busy", int'(busy0), 0);
    check("reset done", int'(done1), 0);
    reset = 1;

    // T1
    cycle(1, 4'd3, 4'd5, 0, 0, 0, 0);
    idle(1);
    check("T1 pass_cnt", int'(pass0), 1);
    check("T1 fail_cnt", int'(fail0), 0);

    // T2: sub 2-5 -> 5'h1D, add 15+15 -> 30, back to back
    cycle(1, 4'd2, 4'd5, 1, 0, 0, 0);
    cycle(1, 4'd15, 4'd15, 0, 0, 0, 0);
    idle(1);
    check("T2 pass_cnt", int'(pass0), 3);

    // T3
    cycle(1, 4'd4, 4'd4, 0, 0, 1, 0);
    idle(1);
    check("T3 mismatch", int'(mis0), 1);
    check("T3 fail_cnt", int'(fail0), 1);
    check("T3 first_err_exp", int'(fee0), 8);
    check("T3 first_err_got", int'(feg0), 9);
    idle(1);
    check("T3 mismatch pulse", int'(mis0), 0);
    cycle(1, 4'd1, 4'd1, 0, 0, 1, 0);
    idle(1);
    check("T3 fail_cnt 2", int'(fail0), 2);
    check("T3 first_err_exp held", int'(fee0), 8);
    check("T3 first_err_got held", int'(feg0), 9);
    idle(3);

    rand_run(300);
    idle(4);

    // T4: five passes after a clear; CNT_W=2 instance saturates at 3
    cycle(0, '0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, W'(i), W'(i + 1), 0, 0, 0, 0);
    idle(3);
    check("T4 pass_cnt sat", int'(pass1), 3);
    check("T4 pass_cnt wide", int'(pass0), 5);

    // T5: three back-to-back issues, end_of_test on the last, one issue during DRAIN
    cycle(1, 4'd1, 4'd2, 0, 0, 0, 0);
    cycle(1, 4'd3, 4'd4, 1, 0, 0, 0);
    cycle(1, 4'd9, 4'd6, 0, 1, 0, 0);
    check("T5 busy", int'(busy1), 1);
    check("T5 done early", int'(done1), 0);
    cycle(1, 4'd7, 4'd7, 0, 0, 0, 0);
    n = 0;
    while (!done1 && n < 20) begin
      idle(1);
      n++;
    end
    check("T5 done reached", int'(done1), 1);
    check("T5 drain issue ignored", int'(pass0), 8);

    // T6: clear in DONE, then reset with checks in flight
    cycle(0, '0, '0, 0, 0, 0, 1);
    check("T6 clear done", int'(done0), 0);
    check("T6 clear pass_cnt", int'(pass0), 0);
    cycle(1, 4'd5, 4'd6, 0, 0, 0, 0);
    cycle(1, 4'd8, 4'd2, 1, 0, 0, 0);
    reset = 0;
    #1;
    check("T6 reset busy", int'(busy1), 0);
    check("T6 reset pass_cnt", int'(pass1), 0);
    idle(2);
    reset = 1;

    rand_run(200);
    cycle(0, '0, '0, 0, 1, 0, 0);
    idle(6);
    check("final done", int'(done1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
